// File: rtl/sha256_pkg.sv
// Shared SHA-256 definitions: schedule FSM states, sizing constants and the
// small sigma functions used by both the message schedule and the round stage.
package sha256_pkg;

  localparam int WORD_W  = 32;
  localparam int ROUNDS  = 64;
  localparam int WIN_LEN = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } sched_state_t;

  // sigma0(x) = ROTR7 ^ ROTR18 ^ SHR3
  function automatic logic [WORD_W-1:0] sigma0_small(input logic [WORD_W-1:0] x);
    return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ {3'b000, x[31:3]};
  endfunction

  // sigma1(x) = ROTR17 ^ ROTR19 ^ SHR10
  function automatic logic [WORD_W-1:0] sigma1_small(input logic [WORD_W-1:0] x);
    return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ {10'b0, x[31:10]};
  endfunction

endpackage

// File: rtl/sha256_w_expand.sv
// Combinational generator of the next schedule word W_{t+16} from the
// current 16-word window taps win[0], win[1], win[9] and win[14].
module sha256_w_expand
  import sha256_pkg::*;
(
  input  logic [WORD_W-1:0] w0,
  input  logic [WORD_W-1:0] w1,
  input  logic [WORD_W-1:0] w9,
  input  logic [WORD_W-1:0] w14,
  output logic [WORD_W-1:0] w_new
);

  // Four-term sum modulo 2^32; carries out of bit 31 are simply dropped.
  assign w_new = sigma1_small(w14) + w9 + sigma0_small(w1) + w0;

endmodule

// File: rtl/sha256_msg_sched.sv
// SHA-256 message schedule: loads one 512-bit block and streams W_0..W_63,
// one word per unstalled cycle, followed by a one-cycle end-of-computation.
//
// Flow control: w_out/t_out are meaningful only while w_valid is high. The
// consumer takes the word on every rising edge where w_valid=1 and hold=0;
// while hold=1 the word, index and window stay frozen. soc is a request that
// is only honoured in IDLE (busy=0) and is dropped otherwise.
module sha256_msg_sched
  import sha256_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        soc,
  input  logic [511:0] block_in,
  input  logic        hold,
  output logic [31:0] w_out,
  output logic [5:0]  t_out,
  output logic        w_valid,
  output logic        busy,
  output logic        eoc
);

  sched_state_t      state_q, state_d;
  logic [WORD_W-1:0] win_q [WIN_LEN];
  logic [5:0]        t_q;
  logic [WORD_W-1:0] w_next;

  sha256_w_expand u_w_expand (
    .w0    (win_q[0]),
    .w1    (win_q[1]),
    .w9    (win_q[9]),
    .w14   (win_q[14]),
    .w_new (w_next)
  );

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic: IDLE -> RUN on soc, RUN -> DONE after the last word
  // is consumed, DONE lasts exactly one cycle.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (soc) state_d = RUN;
      RUN:  if (!hold && (t_q == 6'(ROUNDS - 1))) state_d = DONE;
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Window register file and round counter: load on accepted soc, shift and
  // append W_{t+16} on every unstalled RUN cycle. The counter wraps 63 -> 0,
  // so it is already zero when the FSM returns to IDLE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < WIN_LEN; i++) win_q[i] <= '0;
      t_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (soc) begin
            for (int i = 0; i < WIN_LEN; i++)
              win_q[i] <= block_in[511 - 32*i -: 32];
            t_q <= '0;
          end
        end
        RUN: begin
          if (!hold) begin
            for (int i = 0; i < WIN_LEN - 1; i++) win_q[i] <= win_q[i+1];
            win_q[WIN_LEN-1] <= w_next;
            t_q <= t_q + 6'd1;
          end
        end
        default: ;
      endcase
    end
  end

  // Outputs come only from registers gated by the registered state, so
  // neither hold nor soc has a combinational path to them.
  assign w_valid = (state_q == RUN);
  assign busy    = (state_q != IDLE);
  assign eoc     = (state_q == DONE);
  assign w_out   = w_valid ? win_q[0] : '0;
  assign t_out   = w_valid ? t_q : '0;

endmodule

// File: tb/tb_sha256_msg_sched.sv
// Directed and randomised bench for sha256_msg_sched: drives blocks with
// optional stalls and checks every consumed word against a reference model.
module tb_sha256_msg_sched;

  logic         clk;
  logic         rst_n;
  logic         soc;
  logic [511:0] block_in;
  logic         hold;
  logic [31:0]  w_out;
  logic [5:0]   t_out;
  logic         w_valid;
  logic         busy;
  logic         eoc;

  sha256_msg_sched dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .soc      (soc),
    .block_in (block_in),
    .hold     (hold),
    .w_out    (w_out),
    .t_out    (t_out),
    .w_valid  (w_valid),
    .busy     (busy),
    .eoc      (eoc)
  );

  // ---------------- clock / cycle counter ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- bookkeeping ----------------
  int n_checks = 0;
  int n_errors = 0;

  logic [31:0] exp_q[$];
  logic [31:0] got_w [64];
  int          mon_t      = 0;
  int          blk_words  = 0;
  int          eoc_count  = 0;
  int          eoc_cyc    = 0;
  int          soc_cyc    = 0;
  int          blocks_exp = 0;
  logic        prev_eoc   = 1'b0;
  int          hold_mode  = 0;   // 0 none, 1 three cycles at t=20 and t=63, 2 random 20%
  int          held_n     = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic logic [31:0] ref_s0(input logic [31:0] x);
    return ((x >> 7) | (x << 25)) ^ ((x >> 18) | (x << 14)) ^ (x >> 3);
  endfunction

  function automatic logic [31:0] ref_s1(input logic [31:0] x);
    return ((x >> 17) | (x << 15)) ^ ((x >> 19) | (x << 13)) ^ (x >> 10);
  endfunction

  task automatic push_model(input logic [511:0] blk);
    logic [31:0] w [64];
    for (int t = 0; t < 16; t++) w[t] = blk[511 - 32*t -: 32];
    for (int t = 16; t < 64; t++)
      w[t] = ref_s1(w[t-2]) + w[t-7] + ref_s0(w[t-15]) + w[t-16];
    for (int t = 0; t < 64; t++) exp_q.push_back(w[t]);
  endtask

  // ---------------- stall generator ----------------
  always @(posedge clk) begin
    #1;
    if (hold_mode == 1 && w_valid && (t_out == 6'd20 || t_out == 6'd63)) begin
      if (held_n < 3) begin hold = 1'b1; held_n++; end
      else            hold = 1'b0;
    end else if (hold_mode == 2) begin
      hold = ($urandom_range(0, 99) < 20);
      held_n = 0;
    end else begin
      hold = 1'b0;
      held_n = 0;
    end
  end

  // ---------------- monitor / scoreboard ----------------
  // A word counts as consumed on a cycle with w_valid=1 and hold=0.
  always @(negedge clk) begin
    if (rst_n) begin
      if (w_valid && !hold) begin
        check("q_nonempty", 32'(exp_q.size() > 0), 32'd1);
        if (exp_q.size() > 0) check($sformatf("w_t%0d", mon_t), w_out, exp_q.pop_front());
        check("t_out", 32'(t_out), 32'(mon_t));
        got_w[t_out] = w_out;
        mon_t = (mon_t + 1) % 64;
        blk_words++;
      end
      if (eoc) begin
        check("eoc_width", 32'(prev_eoc), 32'd0);
        check("words_per_blk", 32'(blk_words), 32'd64);
        check("eoc_w_valid", 32'(w_valid), 32'd0);
        blk_words = 0;
        eoc_count++;
        eoc_cyc = cyc;
      end
      prev_eoc = eoc;
    end else begin
      prev_eoc = 1'b0;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic wait_idle(input string tag);
    bit done = 0;
    for (int i = 0; i < 3000 && !done; i++) begin
      @(posedge clk); #1;
      if (!busy) done = 1;
    end
    check({tag, "_idle_timeout"}, 32'(!done), 32'd0);
  endtask

  task automatic wait_t(input logic [5:0] tv);
    bit done = 0;
    for (int i = 0; i < 500 && !done; i++) begin
      @(posedge clk); #1;
      if (w_valid && t_out == tv) done = 1;
    end
    check("wait_t_timeout", 32'(!done), 32'd0);
  endtask

  task automatic wait_eoc();
    bit done = 0;
    for (int i = 0; i < 500 && !done; i++) begin
      @(posedge clk); #1;
      if (eoc) done = 1;
    end
    check("wait_eoc_timeout", 32'(!done), 32'd0);
  endtask

  // Assumes the DUT is idle; raises soc for one cycle.
  task automatic send_block(input logic [511:0] blk);
    @(posedge clk); #1;
    soc = 1'b1;
    block_in = blk;
    soc_cyc = cyc;
    push_model(blk);
    blocks_exp++;
    @(posedge clk); #1;
    soc = 1'b0;
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_w_out"},   w_out,         32'd0);
    check({tag, "_t_out"},   32'(t_out),    32'd0);
    check({tag, "_w_valid"}, 32'(w_valid),  32'd0);
    check({tag, "_busy"},    32'(busy),     32'd0);
    check({tag, "_eoc"},     32'(eoc),      32'd0);
  endtask

  // ---------------- main sequence ----------------
  logic [511:0] abc_blk;
  logic [511:0] ones_blk;
  logic [511:0] junk_blk;
  logic [511:0] rnd_blk;

  initial begin
    abc_blk  = {32'h61626380, {14{32'h00000000}}, 32'h00000018};
    ones_blk = {16{32'hFFFFFFFF}};
    junk_blk = {16{32'hDEADBEEF}};
    rst_n = 1'b0; soc = 1'b0; hold = 1'b0; block_in = '0;

    repeat (2) @(posedge clk);
    #2;
    check_outputs_zero("reset");
    rst_n = 1'b1;
    repeat (2) @(posedge clk);

    // "abc" with no stall: directed words and latency.
    send_block(abc_blk);
    wait_idle("abc");
    check("abc_w0",  got_w[0],  32'h61626380);
    check("abc_w15", got_w[15], 32'h00000018);
    check("abc_w16", got_w[16], 32'h61626380);
    check("abc_w17", got_w[17], 32'h000F0000);
    check("abc_w63", got_w[63], 32'h12B1EDEB);
    check("abc_eoc_latency", 32'(eoc_cyc - soc_cyc), 32'd65);

    // Same block, 3-cycle stalls at t=20 and t=63: same words, eoc 6 later.
    hold_mode = 1;
    send_block(abc_blk);
    wait_idle("abc_hold");
    hold_mode = 0;
    check("abc_hold_eoc_latency", 32'(eoc_cyc - soc_cyc), 32'd71);
    check("abc_hold_w63", got_w[63], 32'h12B1EDEB);

    // soc in RUN and DONE ignored; soc in the following IDLE cycle accepted.
    send_block(abc_blk);
    wait_t(6'd10);
    soc = 1'b1; block_in = junk_blk;
    @(posedge clk); #1;
    soc = 1'b0;
    wait_eoc();
    soc = 1'b1; block_in = junk_blk;      // in DONE: ignored
    @(posedge clk); #1;
    check("ign_eoc_latency", 32'(eoc_cyc - soc_cyc), 32'd65);
    check("ign_busy_idle", 32'(busy), 32'd0);
    block_in = ones_blk;                   // in IDLE: accepted
    soc_cyc = cyc;
    push_model(ones_blk);
    blocks_exp++;
    @(posedge clk); #1;
    soc = 1'b0;
    check("ones_busy", 32'(busy), 32'd1);
    check("ones_w0_live", w_out, 32'hFFFFFFFF);
    wait_idle("ones");
    // 003FFFFF + 1FFFFFFF + FFFFFFFF + FFFFFFFF mod 2^32
    check("ones_w16", got_w[16], 32'h203FFFFC);
    check("ones_eoc_latency", 32'(eoc_cyc - soc_cyc), 32'd65);

    // Asynchronous reset in the middle of a block.
    send_block(abc_blk);
    wait_t(6'd30);
    @(negedge clk); #2;
    rst_n = 1'b0;
    #1;
    check_outputs_zero("midrst");
    exp_q.delete();
    mon_t = 0;
    blk_words = 0;
    blocks_exp--;
    repeat (2) @(posedge clk);
    #2;
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      check("postrst_w_valid", 32'(w_valid), 32'd0);
      check("postrst_busy", 32'(busy), 32'd0);
    end

    // Back-to-back random blocks with random stalls.
    hold_mode = 2;
    for (int b = 0; b < 12; b++) begin
      for (int i = 0; i < 16; i++) rnd_blk[511 - 32*i -: 32] = $urandom();
      send_block(rnd_blk);
      wait_idle("rnd");
    end
    hold_mode = 0;
    repeat (2) @(posedge clk);

    check("exp_q_drained", 32'(exp_q.size()), 32'd0);
    check("eoc_count", 32'(eoc_count), 32'(blocks_exp));

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

  // Global watchdog.
  initial begin
    #900000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
